// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shift register with a ready/load handshake.
// Emits one bit per clock with valid and first/last frame markers.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             first,
    output logic             last
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [CW-1:0]    cnt, cnt_d;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; the combinational block below uses blocking (=).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            shreg <= shreg_d;
            cnt   <= cnt_d;
        end
    end

    // NOTE: every signal written here is given a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        cnt_d     = cnt;
        out       = 1'b0;
        out_valid = 1'b0;
        first     = 1'b0;
        last      = 1'b0;
        ready     = 1'b0;

        case (state)
            IDLE: begin
                ready = 1'b1;
            end
            SHIFT: begin
                out_valid = 1'b1;
                out       = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
                first     = (cnt == '0);
                last      = (cnt == CNT_LAST);
                ready     = last;
                if (!last) begin
                    shreg_d = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
                    cnt_d   = cnt + 1'b1;
                end else if (!load) begin
                    state_d = IDLE;
                end
            end
        endcase

        // Accept from IDLE, or back-to-back reload on the last bit.
        if (ready && load) begin
            shreg_d = din;
            cnt_d   = '0;
            state_d = SHIFT;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: an LSB-first and an MSB-first serializer checked each
// cycle against a queue-of-pending-bits reference model.
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din0, din1;
    logic         load0, load1;
    logic         ready0, out0, out_valid0, first0, last0;
    logic         ready1, out1, out_valid1, first1, last1;

    int n_pass   = 0;
    int n_checks = 0;

    // Pending bits of the word being shown, front = bit on the wire now.
    bit q0[$];
    bit q1[$];

    // Serial-in shift-right receiver fed from the LSB-first serializer.
    logic [W-1:0] rx_q;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .din(din0), .load(load0), .ready(ready0),
        .out(out0), .out_valid(out_valid0), .first(first0), .last(last0)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .din(din1), .load(load1), .ready(ready1),
        .out(out1), .out_valid(out_valid1), .first(first1), .last(last1)
    );

    always @(posedge clk or negedge rst) begin
        if (!rst)            rx_q <= '0;
        else if (out_valid0) rx_q <= {out0, rx_q[W-1:1]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic compare();
        int s0 = q0.size();
        int s1 = q1.size();
        check("out0",   out0,       (s0 > 0) ? q0[0] : 1'b0);
        check("valid0", out_valid0, s0 > 0);
        check("first0", first0,     s0 == W);
        check("last0",  last0,      s0 == 1);
        check("ready0", ready0,     s0 <= 1);
        check("out1",   out1,       (s1 > 0) ? q1[0] : 1'b0);
        check("valid1", out_valid1, s1 > 0);
        check("first1", first1,     s1 == W);
        check("last1",  last1,      s1 == 1);
        check("ready1", ready1,     s1 <= 1);
    endtask

    // One clock: advance the model with the inputs present at the edge,
    // then compare on the falling edge.
    task automatic cycle();
        bit r0, r1;
        @(posedge clk);
        if (!rst) begin
            q0.delete();
            q1.delete();
        end else begin
            r0 = (q0.size() <= 1);
            r1 = (q1.size() <= 1);
            if (q0.size() > 0) void'(q0.pop_front());
            if (q1.size() > 0) void'(q1.pop_front());
            if (r0 && load0) for (int i = 0; i < W; i++) q0.push_back(din0[i]);
            if (r1 && load1) for (int i = 0; i < W; i++) q1.push_back(din1[W-1-i]);
        end
        @(negedge clk);
        compare();
    endtask

    initial begin
        logic [7:0] stream;
        int         nbits;

        rst = 1'b0; load0 = 1'b0; load1 = 1'b0; din0 = '0; din1 = '0;

        // Reset held, then released idle.
        repeat (2) cycle();
        rst = 1'b1;
        repeat (3) cycle();

        // Single LSB-first word 0001.
        din0 = 4'b0001; load0 = 1'b1;
        cycle();
        load0 = 1'b0; din0 = 4'hE;
        repeat (5) cycle();

        // Back-to-back A then 5, capturing the serial stream.
        stream = '0; nbits = 0;
        for (int k = 0; k < 10; k++) begin
            load0 = (k < 5);
            din0  = (k == 0) ? 4'hA : 4'h5;
            cycle();
            if (out_valid0) begin
                stream = {stream[6:0], out0};
                nbits++;
            end
        end
        check("b2b_stream", stream, 8'b0101_1010);
        check("b2b_nbits",  nbits,  8);

        // Loopback into the shift-right receiver.
        din0 = 4'hC; load0 = 1'b1;
        cycle();
        load0 = 1'b0;
        repeat (4) cycle();
        check("loopback_q", rx_q, 4'hC);
        cycle();

        // MSB-first 1000, with a load during bit 2 that must be ignored.
        din1 = 4'b1000; load1 = 1'b1;
        cycle();
        load1 = 1'b0; din1 = 4'hF;
        cycle();
        load1 = 1'b1;
        cycle();
        load1 = 1'b0;
        repeat (4) cycle();
        check("msb_idle", out_valid1, 1'b0);

        // Reset mid-word, then a fresh word.
        din0 = 4'hF; load0 = 1'b1;
        cycle();
        load0 = 1'b0;
        repeat (2) cycle();
        #2 rst = 1'b0;
        #1;
        check("async_valid", out_valid0, 1'b0);
        check("async_ready", ready0,     1'b1);
        q0.delete();
        q1.delete();
        cycle();
        rst = 1'b1;
        din0 = 4'h3; load0 = 1'b1;
        cycle();
        check("restart_first", first0, 1'b1);
        load0 = 1'b0;
        repeat (5) cycle();

        // Randomized traffic on both serializers.
        for (int k = 0; k < 400; k++) begin
            load0 = ($urandom_range(0, 3) != 0);
            load1 = ($urandom_range(0, 1) != 0);
            din0  = W'($urandom);
            din1  = W'($urandom);
            cycle();
        end
        load0 = 1'b0; load1 = 1'b0;
        repeat (6) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in / serial-out shift register: the transmit-side counterpart of the team's serial-in shift-right register (`srregister`). It accepts a WIDTH-bit word through a ready/load handshake and emits it one bit per clock, with a valid strobe and frame markers. With default parameters, its `out` pin can drive the `in` pin of `srregister`, and the receiver reassembles the word unchanged after WIDTH shifts.

## Interface
Parameters:
- `WIDTH`, default 4: word width in bits; legal values ≥ 2.
- `LSB_FIRST`, default 1: 1 sends bit 0 first (matches a shift-right receiver); 0 sends bit WIDTH-1 first.

Ports:
- `clk`  input  1: single clock; all state changes on the rising edge.
- `rst`  input  1: asynchronous, active-low reset (assert 0 to reset).
- `din`  input  WIDTH: parallel word; sampled only on an accept edge.
- `load`  input  1: request to transmit `din`.
- `ready`  output  1: the block accepts `load` at the next rising edge.
- `out`  output  1: serial data bit.
- `out_valid`  output  1: `out` carries a data bit this cycle.
- `first`  output  1: `out` is bit 0 of a word (in transmission order).
- `last`  output  1: `out` is the final bit of a word.

## Operation
- State machine: IDLE and SHIFT.
  - Internal registers: shift register `shreg[WIDTH-1:0]` and bit counter `cnt`, $clog2(WIDTH) bits wide.
- Accept: a rising edge with `load`=1 and `ready`=1.
  - `shreg` ← `din`, `cnt` ← 0, state ← SHIFT.
  - `load` with `ready`=0 is ignored and not queued. The requester must hold it.
- In SHIFT, the output is taken directly from `shreg`:
  - `out` = `shreg[0]` when LSB_FIRST=1, else `shreg[WIDTH-1]`.
- SHIFT edge with `cnt` < WIDTH-1:
  - `shreg` shifts toward the output end, with zero fill. This is a right shift when LSB_FIRST=1, a left shift otherwise.
  - `cnt` ← `cnt`+1.
- SHIFT edge with `cnt` = WIDTH-1 (the last bit):
  - If `load`=1: reload exactly as on an accept. The next word follows back-to-back with no gap.
  - Otherwise: state ← IDLE.
- Flag decode:
  - `out_valid` = (state==SHIFT).
  - `first` = SHIFT and `cnt`==0.
  - `last` = SHIFT and `cnt`==WIDTH-1.
  - `ready` = IDLE or `last`.
- In IDLE: `out`=0, `out_valid`=0, `first`=0, `last`=0, `ready`=1.
- Reset values (while `rst`=0, taking effect immediately without a clock):
  - state=IDLE, `shreg`=0, `cnt`=0.
  - Outputs: `out`=0, `out_valid`=0, `first`=0, `last`=0, `ready`=1.
- Reset mid-word: the word is aborted and dropped, with no partial completion. After `rst` deasserts, the first accept starts a fresh word at bit 0.
- `din` changing after an accept has no effect on the word in flight.

## Timing
- Latency: bit 0 appears on `out` in the cycle after the accept edge, with `out_valid`=1 and `first`=1.
- Duration: each word occupies exactly WIDTH consecutive `out_valid` cycles. `last` is high only in the WIDTH-th cycle.
- Throughput: one word per WIDTH cycles when `load` is held high, with no idle bubble between words.
  - On a back-to-back boundary, `last` (old word) is followed immediately by `first` (new word).
- Without a reload, `out_valid` drops in the cycle after `last`.
- `ready` falls in the cycle after an accept and stays low for WIDTH-1 cycles. It rises again in the `last` cycle.
- All outputs are decoded from registered state only, with no combinational path from inputs to outputs. A registered-output implementation is permitted if it keeps exactly this cycle behaviour.

## Test plan
- Reset → outputs: hold `rst`=0 for 2 cycles → `out`=0, `out_valid`=0, `first`=0, `last`=0, `ready`=1. Release `rst` with `load`=0 for 3 cycles → outputs unchanged.
- Single word, LSB_FIRST=1, WIDTH=4: `din`=4'b0001 with a 1-cycle `load` → `out`=1,0,0,0 over 4 `out_valid` cycles.
  - `first` is high in cycle 1, `last` in cycle 4, `ready`=0 in cycles 1–3.
  - One cycle later, `out_valid`=0.
- Back-to-back: hold `load`=1 with `din`=4'hA and then 4'h5 → `out`=0,1,0,1,1,0,1,0 over 8 contiguous `out_valid` cycles. `last`/`first` are adjacent at cycles 4/5.
- Loopback: drive `srregister.in` from `out`, clocked only while `out_valid`=1. Send 4'hC → receiver `q`=4'hC after the 4th bit.
- MSB_FIRST (LSB_FIRST=0), `din`=4'b1000 → `out`=1,0,0,0. Also assert `load` during cycle 2 → it is ignored; the block returns to IDLE after 4 bits.
- Reset mid-word: accept 4'hF, pull `rst` low during bit 2 → `out_valid`=0 immediately. After release, accept 4'h3 → `out`=1,1,0,0 with `first` set on bit 0.
